// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus bundle: instruction-SRAM-like request/response channel plus the
// valid/ready handshake towards decode. The fetch stage takes the master side.
interface ifu_fetch_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adel;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata,
        output id_valid,
        input  id_ready,
        output id_pc,
        output id_inst,
        output id_adel
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata,
        input  id_valid,
        output id_ready,
        input  id_pc,
        input  id_inst,
        input  id_adel
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction-fetch request/buffer stage. Issues one bus request per consumed PC,
// collects in-order responses into a circular buffer tagged with their PC and
// hands completed entries to decode. A flush drops buffered entries and counts
// in-flight responses so they can be discarded when they return.
module ifu_fetch #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        pc_stall,
    ifu_fetch_if.master bus
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    logic [31:0]      slot_pc_q   [DEPTH];
    logic [31:0]      slot_inst_q [DEPTH];
    logic [DEPTH-1:0] slot_adel_q;
    logic [DEPTH-1:0] slot_filled_q;

    ptr_t head_q;
    ptr_t fill_q;
    ptr_t tail_q;
    cnt_t count_q;
    // Allocated slots still waiting for their data; disambiguates fill == tail.
    cnt_t unfilled_q;
    cnt_t discard_q;

    logic        aligned;
    logic        credit;
    logic [CntW:0] used;
    logic        alloc_req;
    logic        alloc_adel;
    logic        alloc;
    logic        drop;
    logic        fill_en;
    logic        pop;
    cnt_t        flush_discard;

    // Request issue, allocation, response routing and pop decisions.
    always_comb begin
        used          = {1'b0, count_q} + {1'b0, discard_q};
        credit        = used < (CntW + 1)'(DEPTH);
        aligned       = (pc[1:0] == 2'b00);
        bus.inst_req  = aligned && credit && !flush && !rst;
        bus.inst_addr = pc;
        alloc_req     = bus.inst_req && bus.inst_addr_ok;
        // A misaligned PC waits for older fetches so the error entry stays in order.
        alloc_adel    = !aligned && credit && !flush && !rst &&
                        (unfilled_q == '0) && (discard_q == '0);
        alloc         = alloc_req || alloc_adel;
        pc_stall      = !alloc;
        drop          = bus.inst_data_ok && (discard_q != '0);
        // Data with nothing outstanding is a protocol violation and is ignored.
        fill_en       = bus.inst_data_ok && (discard_q == '0) && (unfilled_q != '0);
        pop           = slot_filled_q[head_q] && bus.id_ready;
        flush_discard = discard_q + unfilled_q -
                        cnt_t'(bus.inst_data_ok && ((discard_q != '0) || (unfilled_q != '0)));
    end

    // Decode-facing view of the head slot.
    always_comb begin
        bus.id_valid = slot_filled_q[head_q];
        bus.id_pc    = slot_pc_q[head_q];
        bus.id_inst  = slot_inst_q[head_q];
        bus.id_adel  = slot_adel_q[head_q];
    end

    // Buffer and pointer state; flush overrides allocate, fill and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q        <= '0;
            fill_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            unfilled_q    <= '0;
            discard_q     <= '0;
            slot_adel_q   <= '0;
            slot_filled_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_pc_q[i]   <= '0;
                slot_inst_q[i] <= '0;
            end
        end else if (flush) begin
            head_q        <= '0;
            fill_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            unfilled_q    <= '0;
            slot_filled_q <= '0;
            discard_q     <= flush_discard;
        end else begin
            if (fill_en) begin
                slot_inst_q[fill_q]   <= bus.inst_rdata;
                slot_filled_q[fill_q] <= 1'b1;
            end
            if (pop) begin
                // Clear so a drained slot never looks valid when head reaches it.
                slot_filled_q[head_q] <= 1'b0;
                head_q                <= head_q + 1'b1;
            end
            if (alloc) begin
                slot_pc_q[tail_q]     <= pc;
                slot_inst_q[tail_q]   <= '0;
                slot_adel_q[tail_q]   <= alloc_adel;
                slot_filled_q[tail_q] <= alloc_adel;
                tail_q                <= tail_q + 1'b1;
            end
            // An error entry is born filled, so the fill pointer skips over it.
            fill_q     <= fill_q + ptr_t'(fill_en) + ptr_t'(alloc_adel);
            count_q    <= count_q + cnt_t'(alloc) - cnt_t'(pop);
            unfilled_q <= unfilled_q + cnt_t'(alloc_req) - cnt_t'(fill_en);
            discard_q  <= discard_q - cnt_t'(drop);
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomised bench for ifu_fetch. A queue-based model tracks allocated fetches,
// outstanding bus responses and the discard count; expected decode entries go to a
// scoreboard that a separate monitor drains whenever decode takes an entry.
module tb_ifu_fetch;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BootPc = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] pc;
    logic        pc_stall;

    ifu_fetch_if bus ();

    ifu_fetch #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .pc       (pc),
        .flush    (flush),
        .pc_stall (pc_stall),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        filled;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } exp_t;

    ent_t        ent[$];   // allocated entries, oldest first
    exp_t        sb[$];    // expected decode stream
    logic [31:0] pend[$];  // addresses accepted by the bus, awaiting data
    int          discard;
    int          n_chk;
    int          n_fail;
    logic [31:0] pc_next;
    logic        prev_rst;
    exp_t        mon_e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hc3a5, a[31:16] ^ 16'h1e0f};
    endfunction

    function automatic logic [31:0] rand_target(input int p_mis);
        logic [31:0] t;
        t = BootPc + ($urandom_range(0, 1023) << 2);
        if ($urandom_range(0, 99) < p_mis) t = t + 32'($urandom_range(1, 3));
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Decode side: every accepted entry must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b0 && flush === 1'b0 && bus.id_valid === 1'b1 && bus.id_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_empty at %0t: got id_pc %h, expected no entry", $time, bus.id_pc);
            end else begin
                mon_e = sb.pop_front();
                chk("id_pc", bus.id_pc, mon_e.pc);
                chk("id_inst", bus.id_inst, mon_e.inst);
                chk("id_adel", 32'(bus.id_adel), 32'(mon_e.adel));
            end
        end
    end

    // One clock cycle: drive inputs, check combinational outputs, advance the model.
    task automatic step(input logic r, input int p_aok, input int p_dok, input int p_rdy,
                        input int p_flush, input int p_mis);
        int   unfilled;
        logic credit;
        logic e_req;
        logic e_areq;
        logic e_adel;
        logic e_valid;
        logic e_pop;
        logic dok;
        logic done;

        #1;
        rst              = r;
        pc               = pc_next;
        flush            = ($urandom_range(0, 99) < p_flush);
        bus.inst_addr_ok = ($urandom_range(0, 99) < p_aok);
        dok              = (pend.size() > 0) && ($urandom_range(0, 99) < p_dok);
        bus.inst_data_ok = dok;
        bus.inst_rdata   = dok ? mem_word(pend[0]) : $urandom();
        bus.id_ready     = ($urandom_range(0, 99) < p_rdy);
        #1;

        unfilled = 0;
        foreach (ent[i]) if (!ent[i].filled) unfilled++;
        credit  = (ent.size() + discard) < DEPTH;
        e_req   = !rst && !flush && credit && (pc[1:0] == 2'b00);
        e_areq  = e_req && bus.inst_addr_ok;
        e_adel  = !rst && !flush && credit && (pc[1:0] != 2'b00) &&
                  (unfilled == 0) && (discard == 0);
        e_valid = (ent.size() > 0) && ent[0].filled;
        e_pop   = e_valid && bus.id_ready && !flush && !rst;

        if (prev_rst && !rst) begin
            chk("reset_id_valid", 32'(bus.id_valid), 32'd0);
            chk("reset_id_pc", bus.id_pc, 32'd0);
            chk("reset_id_inst", bus.id_inst, 32'd0);
            chk("reset_id_adel", 32'(bus.id_adel), 32'd0);
        end
        chk("inst_req", 32'(bus.inst_req), 32'(e_req));
        chk("pc_stall", 32'(pc_stall), 32'(!(e_areq || e_adel)));
        if (e_req) chk("inst_addr", bus.inst_addr, pc);
        if (!rst) chk("id_valid", 32'(bus.id_valid), 32'(e_valid));

        @(posedge clk);
        prev_rst = rst;
        if (rst) begin
            ent.delete();
            sb.delete();
            pend.delete();
            discard = 0;
            pc_next = BootPc;
        end else if (flush) begin
            discard = discard + unfilled - (dok ? 1 : 0);
            if (dok) pend.delete(0);
            ent.delete();
            sb.delete();
            pc_next = rand_target(p_mis);
        end else begin
            if (dok) begin
                pend.delete(0);
                if (discard > 0) begin
                    discard--;
                end else begin
                    done = 1'b0;
                    foreach (ent[i]) begin
                        if (!done && !ent[i].filled) begin
                            ent[i].filled = 1'b1;
                            done = 1'b1;
                        end
                    end
                end
            end
            if (e_pop) ent.delete(0);
            if (e_areq) begin
                ent.push_back('{pc: pc, filled: 1'b0});
                pend.push_back(pc);
                sb.push_back('{pc: pc, inst: mem_word(pc), adel: 1'b0});
            end
            if (e_adel) begin
                ent.push_back('{pc: pc, filled: 1'b1});
                sb.push_back('{pc: pc, inst: 32'd0, adel: 1'b1});
            end
            if (e_areq || e_adel) pc_next = pc + 32'd4;
        end
    endtask

    initial begin
        n_chk            = 0;
        n_fail           = 0;
        discard          = 0;
        prev_rst         = 1'b0;
        pc_next          = BootPc;
        rst              = 1'b1;
        flush            = 1'b0;
        pc               = BootPc;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = '0;
        bus.id_ready     = 1'b0;

        for (int i = 0; i < 3; i++) step(1'b1, 0, 0, 0, 0, 0);
        // Back-to-back streaming with a perfect bus and decode.
        for (int i = 0; i < 200; i++) step(1'b0, 100, 100, 100, 0, 0);
        // Decode mostly stalled: buffer fills and request issue stops.
        for (int i = 0; i < 300; i++) step(1'b0, 100, 70, 5, 0, 0);
        // Slow bus, occasional redirects and misaligned targets.
        for (int i = 0; i < 1500; i++) step(1'b0, 60, 50, 60, 4, 15);
        for (int i = 0; i < 2; i++) step(1'b1, 50, 50, 50, 0, 0);
        for (int i = 0; i < 1000; i++) step(1'b0, 70, 60, 70, 10, 10);
        for (int i = 0; i < 50; i++) step(1'b0, 0, 100, 100, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch request/buffer stage that sits directly downstream of the PC register. Each cycle it takes the current PC and issues an instruction-SRAM-like bus request, stalling the PC register until the address is accepted. It queues in-order responses in a small buffer with each entry's PC and presents them to decode through a valid/ready handshake. On flush it drops all buffered and in-flight fetches.

## Interface
- `DEPTH`, 4: buffer entries, power of two, ≥2; also the maximum number of in-flight plus buffered fetches.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc` in 32: current fetch PC from the PC register.
- `flush` in 1: discard all buffered and in-flight fetches (pipeline redirect).
- `pc_stall` out 1: hold the PC register; 0 only in a cycle where the current `pc` is consumed.
- `inst_req` out 1: bus request valid.
- `inst_addr` out 32: bus address, equal to `pc`.
- `inst_addr_ok` in 1: bus accepts the address this cycle.
- `inst_data_ok` in 1: in-order read data return, never in the same cycle as its own `addr_ok`.
- `inst_rdata` in 32: instruction word, valid with `inst_data_ok`.
- `id_valid` out 1: head buffer entry is complete.
- `id_ready` in 1: decode accepts the head entry.
- `id_pc` out 32: PC of the head entry.
- `id_inst` out 32: instruction of the head entry (0 when `id_adel`).
- `id_adel` out 1: head entry carries an address-error exception (misaligned PC).

## Operation
- **Buffer contents.** The buffer is a circular FIFO of `DEPTH` slots. Each slot holds `{pc, inst, adel, filled}`. Pointers are `head`, `fill` (the oldest unfilled slot) and `tail`. `count` is the number of allocated slots.
- **Discard counter.** `discard` (width log2(DEPTH)+1) holds the number of accepted requests whose responses must be dropped.
- **Credit.** `credit = (count + discard < DEPTH)`, computed from registered state only. A pop in the same cycle does not free credit.
- **Aligned PC** (`pc[1:0]==0`): `inst_req = credit && !flush && !rst`.
  - On `inst_req && inst_addr_ok`, allocate a slot at `tail` with `pc`, `filled=0`, `adel=0`.
  - In that cycle `pc_stall = 0`; otherwise `pc_stall = 1`.
- **Misaligned PC.** `inst_req = 0`. When `credit && !flush` and no unfilled slots remain and `discard==0`, allocate the slot already filled: `adel=1`, `inst=0`. In that cycle `pc_stall = 0`.
- **Response routing** on `inst_data_ok`:
  - If `discard>0`, decrement `discard` and drop the data.
  - Otherwise write `inst_rdata` into slot `fill`, set `filled=1`, and advance `fill`.
  - A `data_ok` with no unfilled slot and `discard==0` is a bus protocol violation and is ignored.
- **Pop.** `id_valid = slot[head].filled`. On `id_valid && id_ready`, advance `head` and decrement `count`.
- **Flush** has priority over allocate, fill and pop in that cycle:
  - `count`, `head`, `fill` and `tail` are cleared.
  - `discard_next = discard + unfilled − inst_data_ok`.
  - No request is issued and `pc_stall = 1` in the flush cycle.
- **Same-cycle events.** Allocate, fill and pop may occur in the same cycle. `count_next = count + alloc − pop`.

## Timing
- **Reset values.** `count=0`, `discard=0`, all pointers 0, all `filled=0`. In the cycle after reset: `id_valid=0`, `id_pc=0`, `id_inst=0`, `id_adel=0`. While `rst` is high: `inst_req=0`, `pc_stall=1`.
- **Combinational paths.** `inst_req`, `inst_addr` and `pc_stall` are combinational from `pc`, `inst_addr_ok`, `flush` and registered state. There is no combinational path from `id_ready`.
- **Latency.** `id_valid` rises in the cycle after `inst_data_ok`. Minimum PC-to-decode latency is 2 cycles: address accepted in cycle N, data in N+1, `id_valid` in N+2.
- **Throughput.** With `addr_ok` held high, data returned in the next cycle, and `id_ready` high, the block sustains one fetch per cycle once `DEPTH ≥ 3`.
- **Buffer full.** `count + discard == DEPTH` forces `inst_req=0` and `pc_stall=1` until a pop or a drop frees a slot. The freed credit takes effect the following cycle.
- **Wrap-around.** Pointers wrap modulo `DEPTH`. Full and empty are distinguished by `count`, not by pointer equality.
- **Reset mid-operation.** `rst` clears all state at once. Responses still in flight on the bus are the bus's responsibility, since reset is global.

## Test plan
- **Streaming fetch.** Reset, then `pc` steps 0xbfc00000, +4, +8 with `addr_ok=1`, `data_ok` one cycle later, `id_ready=1` → `id_valid` from cycle 3. `id_pc`/`id_inst` appear in order, `pc_stall` stays low.
- **Backpressure to full.** `id_ready=0` with `DEPTH=4` → exactly 4 requests are accepted. After that `inst_req=0` and `pc_stall=1`. Raising `id_ready` drains 4 entries and request issue resumes one cycle after the first pop.
- **Flush with in-flight fetches.** Two addresses are accepted with no data yet, and one entry is buffered; assert `flush` → `id_valid=0` the next cycle and `discard=2`. The next two `data_ok` words are dropped, and the third lands with the new PC.
- **Flush coinciding with data.** `flush` and `inst_data_ok` in the same cycle with 1 unfilled slot → `discard=0` afterwards, and no stale instruction is ever presented.
- **Misaligned PC.** `pc=0xbfc00002` with an empty buffer → no `inst_req`. The entry appears with `id_adel=1`, `id_inst=0` and `id_pc=0xbfc00002`, and `pc_stall` is low for one cycle.
- **Slow bus.** `addr_ok` low for 3 cycles → `pc_stall=1` and `inst_addr` stable for those cycles. The entry is allocated only on the `addr_ok` cycle.
